// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage, including the fetch redirect.
// The "master" side drives the ID/EX fields; the "slave" side is the execute stage itself.
`timescale 1ns/1ps
interface execute_stage_if;
  logic        valid_in;
  logic        load_in;
  logic        store_in;
  logic        next_sel_in;
  logic        branch_result_in;
  logic        reg_write_in;
  logic [3:0]  alu_control_in;
  logic [1:0]  mem_to_reg_in;
  logic [31:0] opa_in;
  logic [31:0] opb_in;
  logic [31:0] opb_data_in;
  logic [31:0] pre_address_in;
  logic [31:0] instruction_in;

  logic        valid_out;
  logic        load_out;
  logic        store_out;
  logic        reg_write_out;
  logic        misaligned_out;
  logic [3:0]  byte_en_out;
  logic [1:0]  mem_to_reg_out;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [31:0] pre_address_out;
  logic [31:0] instruction_out;

  logic        redirect;
  logic [31:0] redirect_addr;

  modport master (
    output valid_in, load_in, store_in, next_sel_in, branch_result_in, reg_write_in,
           alu_control_in, mem_to_reg_in, opa_in, opb_in, opb_data_in,
           pre_address_in, instruction_in,
    input  valid_out, load_out, store_out, reg_write_out, misaligned_out, byte_en_out,
           mem_to_reg_out, alu_result_out, store_data_out, pre_address_out,
           instruction_out, redirect, redirect_addr
  );

  modport slave (
    input  valid_in, load_in, store_in, next_sel_in, branch_result_in, reg_write_in,
           alu_control_in, mem_to_reg_in, opa_in, opb_in, opb_data_in,
           pre_address_in, instruction_in,
    output valid_out, load_out, store_out, reg_write_out, misaligned_out, byte_en_out,
           mem_to_reg_out, alu_result_out, store_data_out, pre_address_out,
           instruction_out, redirect, redirect_addr
  );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: ALU, store lane formatting, misalignment detection,
// EX/MEM register with stall/flush, and branch/jump redirect with a one-cycle shadow.
`timescale 1ns/1ps
module execute_stage (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  execute_stage_if.slave ex
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic        store;
    logic        reg_write;
    logic        misaligned;
    logic [3:0]  byte_en;
    logic [1:0]  mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pre_address;
    logic [31:0] instruction;
  } exmem_t;

  exmem_t      exmem_q, exmem_d, capture;
  logic        shadow_q, shadow_d;
  logic        eff_valid;
  logic        redirect;
  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic        misaligned;
  logic [31:0] store_fmt;
  logic [3:0]  lanes;

  assign shamt = ex.opb_in[4:0];

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    unique case (ex.alu_control_in)
      ALU_ADD:  alu_res = ex.opa_in + ex.opb_in;
      ALU_SUB:  alu_res = ex.opa_in - ex.opb_in;
      ALU_SLL:  alu_res = ex.opa_in << shamt;
      ALU_SLT:  alu_res = {31'b0, $signed(ex.opa_in) < $signed(ex.opb_in)};
      ALU_SLTU: alu_res = {31'b0, ex.opa_in < ex.opb_in};
      ALU_XOR:  alu_res = ex.opa_in ^ ex.opb_in;
      ALU_SRL:  alu_res = ex.opa_in >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(ex.opa_in) >>> shamt);
      ALU_OR:   alu_res = ex.opa_in | ex.opb_in;
      ALU_AND:  alu_res = ex.opa_in & ex.opb_in;
      ALU_PASS: alu_res = ex.opb_in;
      default:  alu_res = '0;
    endcase
  end

  assign funct3  = ex.instruction_in[14:12];
  assign addr_lo = alu_res[1:0];

  // Store funct3 values other than SB/SH are handled as full-word stores.
  always_comb begin
    store_fmt = ex.opb_data_in;
    lanes     = 4'b1111;
    case (funct3)
      F3_BYTE: begin
        store_fmt = {4{ex.opb_data_in[7:0]}};
        lanes     = 4'b0001 << addr_lo;
      end
      F3_HALF: begin
        store_fmt = {2{ex.opb_data_in[15:0]}};
        lanes     = 4'b0011 << addr_lo;
      end
      default: begin
        store_fmt = ex.opb_data_in;
        lanes     = 4'b1111;
      end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (ex.store_in) begin
      case (funct3)
        F3_BYTE: misaligned = 1'b0;
        F3_HALF: misaligned = addr_lo[0];
        default: misaligned = |addr_lo;
      endcase
    end else if (ex.load_in) begin
      case (funct3)
        F3_HALF, F3_HALFU: misaligned = addr_lo[0];
        F3_WORD:           misaligned = |addr_lo;
        default:           misaligned = 1'b0;
      endcase
    end
  end

  // The instruction right after a taken redirect is on the wrong path.
  assign eff_valid = ex.valid_in & ~shadow_q & ~flush;
  assign redirect  = rst & eff_valid & (ex.next_sel_in | ex.branch_result_in) & ~stall;

  assign ex.redirect      = redirect;
  assign ex.redirect_addr = {alu_res[31:1], 1'b0};

  always_comb begin
    capture.valid       = eff_valid;
    capture.load        = eff_valid & ex.load_in & ~misaligned;
    capture.store       = eff_valid & ex.store_in & ~misaligned;
    capture.reg_write   = eff_valid & ex.reg_write_in & ~misaligned;
    capture.misaligned  = eff_valid & misaligned;
    capture.byte_en     = (eff_valid & ex.store_in & ~misaligned) ? lanes : 4'b0000;
    capture.mem_to_reg  = ex.mem_to_reg_in;
    capture.alu_result  = alu_res;
    capture.store_data  = store_fmt;
    capture.pre_address = ex.pre_address_in;
    capture.instruction = ex.instruction_in;
  end

  // Flush wins over stall; flush already zeroes eff_valid, so capture holds a bubble.
  always_comb begin
    exmem_d  = exmem_q;
    shadow_d = shadow_q;
    if (flush) begin
      exmem_d  = capture;
      shadow_d = 1'b0;
    end else if (!stall) begin
      exmem_d  = capture;
      shadow_d = redirect;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exmem_q  <= '0;
      shadow_q <= 1'b0;
    end else begin
      exmem_q  <= exmem_d;
      shadow_q <= shadow_d;
    end
  end

  assign ex.valid_out       = exmem_q.valid;
  assign ex.load_out        = exmem_q.load;
  assign ex.store_out       = exmem_q.store;
  assign ex.reg_write_out   = exmem_q.reg_write;
  assign ex.misaligned_out  = exmem_q.misaligned;
  assign ex.byte_en_out     = exmem_q.byte_en;
  assign ex.mem_to_reg_out  = exmem_q.mem_to_reg;
  assign ex.alu_result_out  = exmem_q.alu_result;
  assign ex.store_data_out  = exmem_q.store_data;
  assign ex.pre_address_out = exmem_q.pre_address;
  assign ex.instruction_out = exmem_q.instruction;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a behavioural model queues the expected
// EX/MEM contents per edge, and a monitor compares them after each rising edge.
`timescale 1ns/1ps
module tb_execute_stage;

  typedef struct {
    bit        valid, load, store, next_sel, branch, reg_write;
    bit [3:0]  aluc;
    bit [1:0]  m2r;
    bit [31:0] opa, opb, opbd, pc, instr;
  } stim_t;

  typedef struct {
    bit        valid, load, store, rw, mis, chk_data;
    bit [3:0]  be;
    bit [1:0]  m2r;
    bit [31:0] alu, sd, pc, instr;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  execute_stage_if bus();

  execute_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  resp_t exp_q[$];
  resp_t m_cur;
  bit    m_shadow = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_alu(bit [3:0] op, bit [31:0] a, bit [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int kind;
    s = zero_stim();
    kind        = int'($urandom_range(0, 9));
    s.valid     = $urandom_range(0, 9) < 8;
    s.load      = kind < 3;
    s.store     = kind >= 3 && kind < 6;
    s.next_sel  = $urandom_range(0, 19) == 0;
    s.branch    = $urandom_range(0, 9) == 0;
    s.reg_write = 1'($urandom_range(0, 1));
    s.aluc      = (s.load || s.store) ? 4'd0 : 4'($urandom_range(0, 15));
    s.m2r       = 2'($urandom_range(0, 3));
    s.opa       = $urandom;
    s.opb       = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 63);
    s.opbd      = $urandom;
    s.pc        = $urandom;
    s.instr     = $urandom;
    return s;
  endfunction

  // One clock cycle: drive at the falling edge, check the combinational redirect,
  // queue the expected EX/MEM contents, then advance the model at the rising edge.
  task automatic step(input stim_t s, input bit st, input bit fl, input bit rs);
    resp_t     nxt;
    bit        nshadow, eff, exp_redir, mis;
    bit [31:0] alu;
    int        addr, f3;
    @(negedge clk);
    bus.valid_in = s.valid;       bus.load_in = s.load;
    bus.store_in = s.store;       bus.next_sel_in = s.next_sel;
    bus.branch_result_in = s.branch;
    bus.reg_write_in = s.reg_write;
    bus.alu_control_in = s.aluc;  bus.mem_to_reg_in = s.m2r;
    bus.opa_in = s.opa;           bus.opb_in = s.opb;
    bus.opb_data_in = s.opbd;     bus.pre_address_in = s.pc;
    bus.instruction_in = s.instr;
    stall = st; flush = fl; rst = rs;
    #1;
    alu       = ref_alu(s.aluc, s.opa, s.opb);
    eff       = s.valid && !m_shadow && !fl;
    exp_redir = rs && eff && (s.next_sel || s.branch) && !st;
    check("redirect", bus.redirect, exp_redir);
    if (exp_redir) check("redirect_addr", bus.redirect_addr, alu & ~32'd1);

    if (!rs) begin
      nxt = '{default: 0};
      nxt.chk_data = 1'b1;
      nshadow = 1'b0;
    end else if (st && !fl) begin
      nxt = m_cur;
      nshadow = m_shadow;
    end else begin
      addr = int'(alu % 4);
      f3   = int'(s.instr / 4096 % 8);
      mis  = 1'b0;
      if (s.store)     mis = (f3 == 0) ? 1'b0 : (f3 == 1) ? (addr % 2 != 0) : (addr != 0);
      else if (s.load) mis = (f3 == 1 || f3 == 5) ? (addr % 2 != 0) : (f3 == 2) ? (addr != 0) : 1'b0;
      nxt = '{default: 0};
      if (f3 == 0) begin
        nxt.sd = (s.opbd % 256) * 32'h0101_0101;
        nxt.be = 4'(1 << addr);
      end else if (f3 == 1) begin
        nxt.sd = (s.opbd % 65536) * 32'h0001_0001;
        nxt.be = 4'(3 << addr);
      end else begin
        nxt.sd = s.opbd;
        nxt.be = 4'hF;
      end
      if (!(eff && s.store && !mis)) nxt.be = 4'h0;
      nxt.valid = eff;
      nxt.load  = eff && s.load && !mis;
      nxt.store = eff && s.store && !mis;
      nxt.rw    = eff && s.reg_write && !mis;
      nxt.mis   = eff && mis;
      nxt.m2r   = s.m2r;
      nxt.alu   = alu;
      nxt.pc    = s.pc;
      nxt.instr = s.instr;
      nshadow   = fl ? 1'b0 : exp_redir;
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    m_cur    = nxt;
    m_shadow = nshadow;
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_out",      bus.valid_out,      e.valid);
        check("load_out",       bus.load_out,       e.load);
        check("store_out",      bus.store_out,      e.store);
        check("reg_write_out",  bus.reg_write_out,  e.rw);
        check("misaligned_out", bus.misaligned_out, e.mis);
        check("byte_en_out",    bus.byte_en_out,    e.be);
        if (e.valid || e.chk_data) begin
          check("alu_result_out",  bus.alu_result_out,  e.alu);
          check("mem_to_reg_out",  bus.mem_to_reg_out,  e.m2r);
          check("pre_address_out", bus.pre_address_out, e.pc);
          check("instruction_out", bus.instruction_out, e.instr);
          if (e.store || e.chk_data) check("store_data_out", bus.store_data_out, e.sd);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    stim_t s;
    m_cur = '{default: 0};

    s = zero_stim();
    s.valid = 1'b1; s.branch = 1'b1; s.reg_write = 1'b1; s.opa = 32'h100; s.opb = 32'h20;
    step(s, 1'b0, 1'b0, 1'b0);
    step(s, 1'b0, 1'b0, 1'b0);
    #1 check("reset_valid_out", bus.valid_out, 32'd0);

    s = zero_stim();
    s.valid = 1'b1; s.reg_write = 1'b1; s.aluc = 4'd0; s.opa = 32'hFFFF_FFFF; s.opb = 32'd1;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("add_wrap_result", bus.alu_result_out, 32'd0);
    check("add_wrap_valid", bus.valid_out, 32'd1);

    s.aluc = 4'd7; s.opa = 32'h8000_0000; s.opb = 32'h24;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("sra_result", bus.alu_result_out, 32'hF800_0000);

    s.aluc = 4'd4; s.opa = 32'd1; s.opb = 32'hFFFF_FFFF;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("sltu_result", bus.alu_result_out, 32'd1);

    s = zero_stim();
    s.valid = 1'b1; s.branch = 1'b1; s.opa = 32'h100; s.opb = 32'h20;
    step(s, 1'b0, 1'b0, 1'b1);
    s = zero_stim();
    s.valid = 1'b1; s.reg_write = 1'b1; s.opa = 32'd3; s.opb = 32'd4;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("shadow_valid_out", bus.valid_out, 32'd0);
    check("shadow_reg_write_out", bus.reg_write_out, 32'd0);
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("after_shadow_valid_out", bus.valid_out, 32'd1);

    s = zero_stim();
    s.valid = 1'b1; s.store = 1'b1; s.opa = 32'h1000; s.opb = 32'd3; s.opbd = 32'hAB;
    s.instr = 32'h0000_0023;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("sb_store_data", bus.store_data_out, 32'hABAB_ABAB);
    check("sb_byte_en", bus.byte_en_out, 32'h8);
    s.opb = 32'd2; s.instr = 32'h0000_2023;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("sw_misaligned", bus.misaligned_out, 32'd1);
    check("sw_misaligned_store_out", bus.store_out, 32'd0);
    check("sw_misaligned_byte_en", bus.byte_en_out, 32'd0);

    s = zero_stim();
    s.valid = 1'b1; s.reg_write = 1'b1; s.opa = 32'd5; s.opb = 32'd7;
    step(s, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stim_t r;
      r = rand_stim();
      r.valid = 1'b1; r.branch = 1'b1;
      step(r, 1'b1, 1'b0, 1'b1);
    end
    #1 check("stall_frozen_result", bus.alu_result_out, 32'd12);
    check("stall_frozen_valid", bus.valid_out, 32'd1);
    step(s, 1'b1, 1'b1, 1'b1);
    #1 check("stall_flush_valid_out", bus.valid_out, 32'd0);

    s = zero_stim();
    s.valid = 1'b1; s.next_sel = 1'b1; s.reg_write = 1'b1; s.opa = 32'h40; s.opb = 32'h4;
    step(s, 1'b0, 1'b0, 1'b1);
    step(s, 1'b1, 1'b0, 1'b0);
    #1 check("reset_in_stall_valid", bus.valid_out, 32'd0);
    check("reset_in_stall_result", bus.alu_result_out, 32'd0);
    s.next_sel = 1'b0;
    step(s, 1'b0, 1'b0, 1'b1);
    #1 check("post_reset_valid", bus.valid_out, 32'd1);

    for (int i = 0; i < 400; i++) begin
      bit st, fl, rs;
      st = $urandom_range(0, 99) < 15;
      fl = $urandom_range(0, 99) < 8;
      rs = $urandom_range(0, 99) >= 2;
      step(rand_stim(), st, fl, rs);
    end

    s = zero_stim();
    step(s, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL: valid_in  in  1  an instruction is present on the ID/EX outputs.
REQ-004 SHALL: load_in, store_in, next_sel_in, branch_result_in, reg_write_in  in  1 each  control fields from ID/EX.
REQ-005 SHALL: alu_control_in  in  4  ALU operation; mem_to_reg_in  in  2  writeback select.
REQ-006 SHALL: opa_in, opb_in, opb_data_in, pre_address_in, instruction_in  in  32 each  operands, rs2 data, PC, instruction.
REQ-007 SHALL: stall  in  1  hold all EX/MEM registers; flush  in  1  insert bubble.
REQ-008 SHALL: valid_out, load_out, store_out, reg_write_out  out  1 each  registered EX/MEM controls.
REQ-009 SHALL: mem_to_reg_out  out  2; alu_result_out, store_data_out, pre_address_out, instruction_out  out  32 each  registered.
REQ-010 SHALL: byte_en_out  out  4  store byte lanes; misaligned_out  out  1  registered misaligned access flag.
REQ-011 SHALL: redirect  out  1; redirect_addr  out  32  combinational PC redirect to fetch.

Function
REQ-012 SHALL: ALU encoding: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS opb; 1011-1111 yield 0.
REQ-013 SHALL: shifts use opb[4:0]; ADD/SUB wrap modulo 2^32; SLT signed, SLTU unsigned, results zero-extended to 32 bits.
REQ-014 SHALL: effective valid = valid_in AND NOT shadow AND NOT flush.
REQ-015 SHALL: redirect = effective valid AND (next_sel_in OR branch_result_in) AND NOT stall; redirect_addr = ALU result with bit 0 cleared.
REQ-016 SHALL: shadow register set for exactly one cycle after any cycle with redirect=1, squashing the wrong-path instruction that follows.
REQ-017 SHALL: shadow holds its value while stall=1 and clears on flush.
REQ-018 SHALL: latency one cycle: with stall=0, EX/MEM registers capture current results at the next rising edge.
REQ-019 SHALL: with stall=1 and flush=0, all EX/MEM registers and shadow hold; redirect forced 0.
REQ-020 SHALL: flush=1 has priority over stall: valid_out, load_out, store_out, reg_write_out, misaligned_out, byte_en_out cleared; data registers may take any value.
REQ-021 SHALL: squashed (ineffective) instruction clears the same control outputs as flush.
REQ-022 SHALL: store_data/byte_en by funct3=instruction_in[14:12] and addr[1:0]=ALU result[1:0]: 000 SB -> byte replicated x4, byte_en=0001<<addr[1:0]; 001 SH -> halfword replicated x2, byte_en=0011<<addr[1:0]; 010 SW -> word, byte_en=1111.
REQ-023 SHALL: misaligned when load or store with SH/LH/LHU at addr[0]=1 or SW/LW at addr[1:0]!=00; then store_out and load_out cleared, byte_en=0000, reg_write_out cleared, misaligned_out=1.
REQ-024 SHALL: byte_en_out=0000 for non-store instructions; other funct3 on store -> treated as SW.
REQ-025 SHALL: pre_address_out, instruction_out, mem_to_reg_out pass through registered unchanged.

Reset
REQ-026 SHALL: while rst=0 at a rising edge, all registered outputs become 0 and shadow becomes 0.
REQ-027 SHALL: redirect stays 0 during any cycle with rst=0.
REQ-028 SHALL: reset mid-operation discards in-flight instruction and shadow; first cycle after rst=1 accepts valid_in normally.

Verification
REQ-029 SHALL: ADD opa=0xFFFFFFFF, opb=1, valid_in=1 -> next cycle alu_result_out=0, valid_out=1.
REQ-030 SHALL: SRA opa=0x80000000, opb=0x24 -> alu_result_out=0xF8000000; SLTU opa=1, opb=0xFFFFFFFF -> 1.
REQ-031 SHALL: branch_result_in=1, opa=0x100, opb=0x20 -> redirect=1, redirect_addr=0x120; next instruction valid_in=1 -> valid_out=0, reg_write_out=0; instruction after that passes.
REQ-032 SHALL: SB store addr 0x1003 data 0x000000AB -> store_data_out=0xABABABAB, byte_en_out=1000; SW addr 0x1002 -> misaligned_out=1, store_out=0, byte_en_out=0000.
REQ-033 SHALL: stall=1 for 3 cycles with changing inputs -> outputs frozen; stall=1 with flush=1 -> valid_out=0 next cycle.
REQ-034 SHALL: rst=0 asserted during stall with shadow=1 -> all outputs 0 next edge; after release, valid instruction produces valid_out=1 one cycle later.
